// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the FP datapath blocks
// (float-to-int converter, adder and later FP units).
package fp_pkg;

    localparam int          FP_EXP_W  = 8;
    localparam int          FP_MANT_W = 23;
    localparam logic [7:0]  FP_BIAS   = 8'd127;
    localparam logic [31:0] INT32_MAX = 32'h7FFFFFFF;
    localparam logic [31:0] INT32_MIN = 32'h80000000;

    // Largest exponent whose truncated magnitude always fits in int32,
    // and the exponent of -2^31, the one representable value of 2^31 magnitude.
    localparam logic [7:0]  FP_INT_EXP_MAX = 8'd157;
    localparam logic [7:0]  FP_MIN_INT_EXP = 8'd158;
    localparam logic [7:0]  FP_EXP_SPECIAL = 8'hFF;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {
        ZERO_FRAC,
        NORMAL,
        MIN_INT,
        OVF
    } fp_class_t;

    function automatic fp_class_t fp_classify(input fp32_t f);
        fp_class_t c;
        if (f.exp < FP_BIAS) begin
            c = ZERO_FRAC;
        end else if (f.exp <= FP_INT_EXP_MAX) begin
            c = NORMAL;
        end else if (f.sign && (f.exp == FP_MIN_INT_EXP) && (f.mant == '0)) begin
            c = MIN_INT;
        end else begin
            c = OVF;
        end
        return c;
    endfunction

    function automatic logic fp_is_nan(input fp32_t f);
        return (f.exp == FP_EXP_SPECIAL) && (f.mant != '0);
    endfunction

endpackage

// File: rtl/fp_to_int_if.sv
// Streaming operand/result bundle of the float-to-int converter; no backpressure.
interface fp_to_int_if;
    logic        _go;
    logic [31:0] Number;
    logic [31:0] Result;
    logic        _done;
    logic        invalid;
    logic        inexact;

    modport master (
        output _go, Number,
        input  Result, _done, invalid, inexact
    );

    modport slave (
        input  _go, Number,
        output Result, _done, invalid, inexact
    );
endinterface

// File: rtl/fp32_align_shift.sv
// Aligns a 24-bit significand to an integer magnitude: left shift for exp>=150,
// right shift with sticky (OR of dropped bits) otherwise.
module fp32_align_shift (
    input  logic [23:0] sig_i,
    input  logic [7:0]  exp_i,
    output logic [31:0] mag_o,
    output logic        sticky_o
);

    logic signed [8:0] sh;
    logic        [8:0] rsh;
    logic        [4:0] rsh_c;
    logic       [47:0] rext;

    always_comb begin
        sh       = $signed({1'b0, exp_i}) - 9'sd150;
        rsh      = 9'(-sh);
        rsh_c    = '0;
        rext     = '0;
        mag_o    = '0;
        sticky_o = 1'b0;
        if (!sh[8]) begin
            if (sh < 9'sd9) begin
                mag_o = {8'b0, sig_i} << sh[3:0];
            end
        end else begin
            // Shifts of 24 or more drop the whole significand into the sticky half.
            rsh_c    = (rsh > 9'd24) ? 5'd24 : rsh[4:0];
            rext     = {sig_i, 24'b0} >> rsh_c;
            mag_o    = {8'b0, rext[47:24]};
            sticky_o = |rext[23:0];
        end
    end

endmodule

// File: rtl/fp_to_int.sv
// IEEE single-precision to int32 converter, round toward zero, 3-cycle
// fixed-latency streaming pipeline with invalid/inexact flags.
module fp_to_int
    import fp_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    fp_to_int_if.slave    bus
);

    logic        vld_p0_q, vld_p1_q, vld_p2_q;
    fp32_t       num_p0_q;

    logic        s_p1_q, nan_p1_q;
    logic [7:0]  e_p1_q;
    logic [22:0] m_p1_q;
    fp_class_t   cls_p1_q;

    logic [31:0] mag_p2_d, mag_p2_q;
    logic        sticky_p2_d, sticky_p2_q;
    logic        s_p2_q, nan_p2_q;
    fp_class_t   cls_p2_q;

    logic [31:0] shf_mag;
    logic        shf_sticky;

    logic [31:0] result_q;
    logic        done_q, invalid_q, inexact_q;

    function automatic logic [31:0] sign_sat(input fp_class_t c, input logic s,
                                             input logic nan, input logic [31:0] mag);
        logic [31:0] r;
        case (c)
            NORMAL:  r = s ? (~mag + 32'd1) : mag;
            MIN_INT: r = INT32_MIN;
            OVF:     r = (SATURATE && !(s && !nan)) ? INT32_MAX : INT32_MIN;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic inexact_of(input fp_class_t c, input logic sticky);
        return ((c == NORMAL) || (c == ZERO_FRAC)) && sticky;
    endfunction

    fp32_align_shift u_align (
        .sig_i    ({1'b1, m_p1_q}),
        .exp_i    (e_p1_q),
        .mag_o    (shf_mag),
        .sticky_o (shf_sticky)
    );

    always_comb begin
        mag_p2_d    = '0;
        sticky_p2_d = 1'b0;
        case (cls_p1_q)
            NORMAL: begin
                mag_p2_d    = shf_mag;
                sticky_p2_d = shf_sticky;
            end
            ZERO_FRAC: sticky_p2_d = (e_p1_q != '0) || (m_p1_q != '0);
            default: ;
        endcase
    end

    // Control and architected outputs: the only state touched by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            invalid_q <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            vld_p0_q <= bus._go;
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
            done_q   <= vld_p2_q;
            // Stage 3: sign / saturate
            if (vld_p2_q) begin
                result_q  <= sign_sat(cls_p2_q, s_p2_q, nan_p2_q, mag_p2_q);
                invalid_q <= (cls_p2_q == OVF);
                inexact_q <= inexact_of(cls_p2_q, sticky_p2_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        // Stage 0: operand capture
        if (bus._go) begin
            num_p0_q <= bus.Number;
        end
        // Stage 1: unpack / classify
        if (vld_p0_q) begin
            s_p1_q   <= num_p0_q.sign;
            e_p1_q   <= num_p0_q.exp;
            m_p1_q   <= num_p0_q.mant;
            cls_p1_q <= fp_classify(num_p0_q);
            nan_p1_q <= fp_is_nan(num_p0_q);
        end
        // Stage 2: align
        if (vld_p1_q) begin
            mag_p2_q    <= mag_p2_d;
            sticky_p2_q <= sticky_p2_d;
            s_p2_q      <= s_p1_q;
            cls_p2_q    <= cls_p1_q;
            nan_p2_q    <= nan_p1_q;
        end
    end

    assign bus.Result  = result_q;
    assign bus._done   = done_q;
    assign bus.invalid = invalid_q;
    assign bus.inexact = inexact_q;

endmodule

// File: tb/tb_fp_to_int.sv
// Randomized bench for fp_to_int: two instances (saturating and non-saturating)
// share one stimulus stream and are checked every cycle against a value-level model.
module tb_fp_to_int;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        go    = 1'b0;
    logic [31:0] num   = '0;

    always #5 clk = ~clk;

    fp_to_int_if if_s ();
    fp_to_int_if if_w ();

    assign if_s._go   = go;
    assign if_s.Number = num;
    assign if_w._go   = go;
    assign if_w.Number = num;

    fp_to_int #(.SATURATE(1'b1)) dut_s (.clk(clk), .reset(rst_n), .bus(if_s));
    fp_to_int #(.SATURATE(1'b0)) dut_w (.clk(clk), .reset(rst_n), .bus(if_w));

    int n_cmp  = 0;
    int n_fail = 0;

    // Operand history: entry k was sampled k+1 edges ago, so entry 3 is due now.
    logic        hv [4];
    logic [31:0] hn [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                hv[i] <= 1'b0;
                hn[i] <= '0;
            end
        end else begin
            hv[0] <= go;
            hn[0] <= num;
            for (int i = 1; i < 4; i++) begin
                hv[i] <= hv[i-1];
                hn[i] <= hn[i-1];
            end
        end
    end

    logic [31:0] last_r [2];
    logic        last_v [2];
    logic        last_x [2];

    // Value-level reference: returns {result, invalid, inexact}.
    function automatic logic [33:0] ref_conv(input logic [31:0] x, input bit sat);
        bit          s, frac, nan, ovf;
        int          e;
        longint      m, sig, mag, v;
        logic [31:0] r;
        s = x[31]; e = int'(x[30:23]); m = longint'(x[22:0]);
        frac = 1'b0; nan = 1'b0; ovf = 1'b0; r = '0; mag = 0; v = 0;
        sig = m + (longint'(1) << 23);
        if (e == 255) begin
            ovf = 1'b1;
            nan = (m != 0);
        end else if (e < 127) begin
            frac = (e != 0) || (m != 0);
        end else if (e >= 159) begin
            ovf = 1'b1;
        end else begin
            if (e >= 150) begin
                mag = sig << (e - 150);
            end else begin
                mag  = sig >> (150 - e);
                frac = (sig % (longint'(1) << (150 - e))) != 0;
            end
            v = s ? -mag : mag;
            if (v > 64'sd2147483647 || v < -64'sd2147483648) ovf = 1'b1;
            else r = v[31:0];
        end
        if (ovf) begin
            frac = 1'b0;
            r = (sat && !(s && !nan)) ? 32'h7FFFFFFF : 32'h80000000;
        end
        return {r, ovf, frac};
    endfunction

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pin(input string name, input logic [31:0] x, input bit sat,
                       input logic [31:0] er, input logic ei, input logic ex);
        logic [33:0] got;
        got = ref_conv(x, sat);
        chk(name, got, {er, ei, ex});
    endtask

    task automatic model_check();
        logic [33:0] e;
        logic [31:0] ar;
        logic        ad, ai, ax, edone;
        string       tag;
        for (int d = 0; d < 2; d++) begin
            tag = (d == 0) ? "sat" : "wrap";
            ar  = (d == 0) ? if_s.Result  : if_w.Result;
            ad  = (d == 0) ? if_s._done   : if_w._done;
            ai  = (d == 0) ? if_s.invalid : if_w.invalid;
            ax  = (d == 0) ? if_s.inexact : if_w.inexact;
            edone = 1'b0;
            if (!rst_n) begin
                last_r[d] = '0; last_v[d] = 1'b0; last_x[d] = 1'b0;
            end else if (hv[3]) begin
                e = ref_conv(hn[3], d == 0);
                last_r[d] = e[33:2]; last_v[d] = e[1]; last_x[d] = e[0];
                edone = 1'b1;
            end
            chk({tag, ".done"}, 34'(ad), 34'(edone));
            chk({tag, ".result"}, {ar, ai, ax}, {last_r[d], last_v[d], last_x[d]});
        end
    endtask

    // Drive at posedge+2, compare at the following negedge, return at next posedge+2.
    task automatic step(input logic g, input logic [31:0] n);
        go  = g;
        num = n;
        @(negedge clk);
        model_check();
        @(posedge clk);
        #2;
    endtask

    task automatic directed(input string name, input logic [31:0] n, input logic [31:0] rs,
                            input logic [31:0] rw, input logic inv, input logic inx);
        step(1'b1, n);
        step(1'b0, '0);
        step(1'b0, '0);
        chk({name, ".early_done"}, 34'(if_s._done), 34'(0));
        step(1'b0, '0);
        chk({name, ".done"}, 34'(if_s._done), 34'(1));
        chk({name, ".sat"}, {if_s.Result, if_s.invalid, if_s.inexact}, {rs, inv, inx});
        chk({name, ".wrap"}, {if_w.Result, if_w.invalid, if_w.inexact}, {rw, inv, inx});
        step(1'b0, '0);
    endtask

    function automatic logic [31:0] rnd_num();
        logic [31:0] x;
        x = $urandom();
        case ($urandom_range(0, 5))
            0: ;
            1: x[30:23] = 8'($urandom_range(118, 160));
            2: x[30:23] = 8'($urandom_range(154, 159));
            3: begin
                x[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) x[22:0] = '0;
            end
            4: x[30:23] = 8'($urandom_range(0, 3));
            default: begin
                x[30:23] = 8'($urandom_range(150, 158));
                x[22:0]  = ($urandom_range(0, 1) == 0) ? 23'h0 : 23'h7FFFFF;
            end
        endcase
        return x;
    endfunction

    initial begin
        last_r[0] = '0; last_r[1] = '0;
        last_v[0] = 1'b0; last_v[1] = 1'b0;
        last_x[0] = 1'b0; last_x[1] = 1'b0;

        pin("pin.one",      32'h3F800000, 1'b1, 32'h00000001, 1'b0, 1'b0);
        pin("pin.m2p5",     32'hC0200000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1);
        pin("pin.half",     32'h3F000000, 1'b1, 32'h00000000, 1'b0, 1'b1);
        pin("pin.minint",   32'hCF000000, 1'b1, 32'h80000000, 1'b0, 1'b0);
        pin("pin.two31",    32'h4F000000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0);
        pin("pin.maxfit",   32'h4EFFFFFF, 1'b1, 32'h7FFFFF80, 1'b0, 1'b0);
        pin("pin.nan_sat",  32'h7FC00000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0);
        pin("pin.nan_wrap", 32'h7FC00000, 1'b0, 32'h80000000, 1'b1, 1'b0);
        pin("pin.ninf",     32'hFF800000, 1'b1, 32'h80000000, 1'b1, 1'b0);
        pin("pin.negzero",  32'h80000000, 1'b1, 32'h00000000, 1'b0, 1'b0);
        pin("pin.denorm",   32'h00000001, 1'b1, 32'h00000000, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #2;
        chk("reset.sat",  {if_s.Result, if_s._done, if_s.invalid, if_s.inexact}, 34'(0));
        chk("reset.wrap", {if_w.Result, if_w._done, if_w.invalid, if_w.inexact}, 34'(0));
        rst_n = 1'b1;
        step(1'b0, '0);

        directed("one",    32'h3F800000, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
        directed("m2p5",   32'hC0200000, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b1);
        directed("half",   32'h3F000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
        directed("minint", 32'hCF000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
        directed("two31",  32'h4F000000, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0);
        directed("maxfit", 32'h4EFFFFFF, 32'h7FFFFF80, 32'h7FFFFF80, 1'b0, 1'b0);
        directed("nan",    32'h7FC00000, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0);
        directed("ninf",   32'hFF800000, 32'h80000000, 32'h80000000, 1'b1, 1'b0);

        step(1'b1, 32'h40400000);
        step(1'b1, 32'h41200000);
        step(1'b1, 32'hC2C80000);
        step(1'b0, '0);
        chk("stream.0", {if_s.Result, if_s._done}, {32'd3, 1'b1});
        step(1'b0, '0);
        chk("stream.1", {if_s.Result, if_s._done}, {32'd10, 1'b1});
        step(1'b0, '0);
        chk("stream.2", {if_s.Result, if_s._done}, {32'hFFFFFF9C, 1'b1});
        step(1'b0, '0);
        chk("stream.hold", {if_s.Result, if_s._done}, {32'hFFFFFF9C, 1'b0});

        step(1'b1, 32'h40400000);
        step(1'b1, 32'h41200000);
        rst_n = 1'b0;
        #1;
        chk("midreset.sat", {if_s.Result, if_s._done, if_s.invalid, if_s.inexact}, 34'(0));
        #1;
        step(1'b0, '0);
        step(1'b0, '0);
        rst_n = 1'b1;
        repeat (5) step(1'b0, '0);
        chk("midreset.quiet", 34'(if_s._done), 34'(0));
        directed("after_reset", 32'h3F800000, 32'h00000001, 32'h00000001, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                step(1'b0, '0);
                rst_n = 1'b1;
            end else begin
                step(($urandom_range(0, 3) != 0), rnd_num());
            end
        end
        repeat (5) step(1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_to_int.md
Name: fp_to_int

Overview:
- Pipelined IEEE 754 single-precision to signed 32-bit two's-complement integer converter; rounds toward zero.
- Converts in the reverse direction of the FP adder datapath, so integer-domain consumers can read adder results.
- Fixed 3-cycle latency and a full-throughput streaming pipeline: one new operand may be accepted every cycle.
- Flags out-of-range and NaN inputs (invalid) and discarded fraction bits (inexact).

Parameters:
- SATURATE, 1: when 1, out-of-range values clamp to 0x7FFFFFFF (positive or NaN) or 0x80000000 (negative). When 0, every invalid case returns 0x80000000.

Ports:
- clk  input  1  single clock; all flops on posedge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- _go  input  1  operand valid; Number is sampled on every clk edge where _go=1.
- Number  input  32  IEEE SP operand: sign in bit 31, exponent in bits 30:23, mantissa in bits 22:0.
- Result  output  32  signed integer result.
- _done  output  1  Result, invalid and inexact are valid this cycle.
- invalid  output  1  NaN, infinity, or magnitude out of int32 range.
- inexact  output  1  nonzero fraction bits were discarded.

Behaviour:
- Reset (reset=0, asynchronous): clears all stage valid bits; Result=0, _done=0, invalid=0, inexact=0.
- Reset mid-operation discards all in-flight operands. No _done is produced for any of them after reset releases.
- Handshake: no backpressure.
  - _done is high exactly 3 cycles after each _go=1 sample (sample at edge N, _done high after edge N+3).
  - Back-to-back _go gives back-to-back _done in order.
  - Result and the flags hold their last valid value while _done=0.
- Stage 1 (unpack/classify): let s, e, m be the sign, exponent and mantissa fields. Register s, e, m, the valid bit and a 2-bit class:
  - ZERO_FRAC when e<127. This includes zero and denormals.
  - NORMAL when 127<=e<=157.
  - MIN_INT when s=1, e=158, m=0.
  - OVF otherwise. This includes infinity and NaN; an is_nan bit marks e=255 with m!=0.
- Stage 2 (align):
  - NORMAL: sig={1'b1,m} (24 bits).
    - e>=150: mag = sig << (e-150), with a shift of 0..7 into a 32-bit field.
    - e<150: mag = sig >> (150-e); sticky = OR of the shifted-out bits.
  - ZERO_FRAC: mag=0; sticky = (e!=0)|(m!=0).
  - Register mag[31:0], sticky, s, class, is_nan and the valid bit.
- Stage 3 (sign/saturate), producing Result, invalid and inexact:
  - NORMAL: Result = s ? -mag : mag; inexact=sticky; invalid=0. mag<=0x7FFFFF80 always, so no overflow is possible.
  - ZERO_FRAC: Result=0; inexact=sticky; invalid=0. -0.0 gives 0 with inexact=0.
  - MIN_INT: Result=0x80000000; invalid=0; inexact=0.
  - OVF with SATURATE=1: Result = (s & ~is_nan) ? 0x80000000 : 0x7FFFFFFF.
  - OVF with SATURATE=0: Result=0x80000000.
  - OVF always sets invalid=1 and inexact=0.
- Width rules:
  - Exponent compares are unsigned 8-bit.
  - Shift amounts are computed in 9-bit signed arithmetic, so no wrap occurs for e<150.
  - Negation is 32-bit two's complement.
- Bubbles: a stage whose valid bit is 0 does not update the output registers.

Decomposition:
- Shared package fp_pkg:
  - typedef fp32_t, a packed struct {sign, exp[7:0], mant[22:0]}.
  - Constants FP_BIAS=127, FP_MANT_W=23, FP_EXP_W=8, INT32_MAX=32'h7FFFFFFF, INT32_MIN=32'h80000000.
  - typedef fp_class_t enum {ZERO_FRAC, NORMAL, MIN_INT, OVF}.
- The FP adder and later FP blocks reuse fp_pkg.
- One sub-module: fp32_align_shift, the stage-2 combinational 24-to-32-bit bidirectional barrel shifter with sticky output. It is independently unit-testable.

Test Plan:
- 0x3F800000 (1.0) with _go at cycle 0 -> _done at cycle 3, Result=1, invalid=0, inexact=0.
- 0xC0200000 (-2.5) -> Result=0xFFFFFFFE (-2), inexact=1. Also 0x3F000000 (0.5) -> Result=0, inexact=1.
- Range limits:
  - 0xCF000000 (-2^31) -> 0x80000000 with invalid=0.
  - 0x4F000000 (2^31) -> 0x7FFFFFFF with invalid=1.
  - 0x4EFFFFFF -> 0x7FFFFF80 with no flags.
- Specials with SATURATE=1:
  - 0x7FC00000 (NaN) -> 0x7FFFFFFF, invalid=1.
  - 0xFF800000 (-inf) -> 0x80000000, invalid=1.
  - Rerun with SATURATE=0: both -> 0x80000000.
- Stream 0x40400000, 0x41200000, 0xC2C80000 on consecutive cycles -> _done high on cycles 3-5 with 3, 10, -100 (0xFFFFFF9C).
- Mid-stream reset: stream the same three operands, then drop reset at cycle 2 -> outputs 0 immediately. After release, no _done until a new _go arrives, then 3-cycle latency again.
